// File: rtl/vga_timing_if.sv
// Raster timing bundle: coordinates, decoded video flags, strobes and frame count.
// The timing generator drives it through master; sprite/game logic reads through slave.
interface vga_timing_if;
    logic [9:0]  xx;
    logic [9:0]  yy;
    logic        aactive;
    logic        o_hs;
    logic        o_vs;
    logic        o_pix_stb;
    logic        o_line_start;
    logic        o_frame_start;
    logic [15:0] o_frame_cnt;

    modport master (
        output xx, yy, aactive, o_hs, o_vs,
        output o_pix_stb, o_line_start, o_frame_start, o_frame_cnt
    );

    modport slave (
        input xx, yy, aactive, o_hs, o_vs,
        input o_pix_stb, o_line_start, o_frame_start, o_frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides i_clk down to the pixel rate and produces
// registered coordinates, sync, active flag, line/frame pulses and a frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_POL = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0]      H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0]      V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0]      HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]      VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]      VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             POL      = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       xx_q, xx_d;
    logic [9:0]       yy_q, yy_d;
    logic             active_q, active_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             pix_stb_q, pix_stb_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             adv;
    logic             h_sync_win;
    logic             v_sync_win;

    always_comb begin
        adv   = (div_q == DIV_LAST);
        div_d = adv ? '0 : div_q + 1'b1;

        xx_d = xx_q;
        yy_d = yy_q;
        if (adv) begin
            if (xx_q == H_LAST) begin
                xx_d = '0;
                yy_d = (yy_q == V_LAST) ? '0 : yy_q + 1'b1;
            end else begin
                xx_d = xx_q + 1'b1;
            end
        end

        h_sync_win = ({1'b0, xx_d} >= HS_START) && ({1'b0, xx_d} < HS_END);
        v_sync_win = ({1'b0, yy_d} >= VS_START) && ({1'b0, yy_d} < VS_END);

        // Flags are decoded from the next coordinates so they land on the same edge
        active_d = active_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        if (adv) begin
            active_d = ({1'b0, xx_d} < H_ACT) && ({1'b0, yy_d} < V_ACT);
            hs_d     = h_sync_win ? POL : ~POL;
            vs_d     = v_sync_win ? POL : ~POL;
        end

        pix_stb_d     = (div_d == DIV_LAST);
        line_start_d  = adv && (xx_d == '0);
        frame_start_d = adv && (xx_d == '0) && (yy_d == '0);
        frame_cnt_d   = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div_q         <= '0;
            xx_q          <= H_LAST;
            yy_q          <= V_LAST;
            active_q      <= 1'b0;
            hs_q          <= ~POL;
            vs_q          <= ~POL;
            pix_stb_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'hFFFF;
        end else begin
            div_q         <= div_d;
            xx_q          <= xx_d;
            yy_q          <= yy_d;
            active_q      <= active_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            pix_stb_q     <= pix_stb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign vga.xx            = xx_q;
    assign vga.yy            = yy_q;
    assign vga.aactive       = active_q;
    assign vga.o_hs          = hs_q;
    assign vga.o_vs          = vs_q;
    assign vga.o_pix_stb     = pix_stb_q;
    assign vga.o_line_start  = line_start_q;
    assign vga.o_frame_start = frame_start_q;
    assign vga.o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance plus two shrunken-raster instances
// (15x10 pixels, CLK_DIV=4 active-low sync and CLK_DIV=1 active-high sync).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic i_rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_timing_if vga_a ();
    vga_timing_if vga_b ();
    vga_timing_if vga_d ();

    // Small raster: H 8+2+3+2=15 (sync x 10..12), V 6+1+2+1=10 (sync y 7..8)
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(4), .SYNC_POL(0)
    ) dut_a (.i_clk(clk), .i_rst(i_rst), .vga(vga_a));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1)
    ) dut_b (.i_clk(clk), .i_rst(i_rst), .vga(vga_b));

    vga_timing_gen dut_d (.i_clk(clk), .i_rst(i_rst), .vga(vga_d));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Model state for instance A, plus aggregate counters over the free-run window
    int mdiv, mx, my, mis_a;
    int a_stb, a_ls, a_hs_low, a_vs_low, a_act;
    int b_stb, b_hs_hi, b_vs_hi;
    int d_hs_low, d_act, d_ls, d_max_x;
    int a_fs_k[$];
    int a_fs_cnt[$];
    int b_fs_k[$];
    logic e_hs, e_vs, e_act, e_ls, e_fs, e_stb;
    logic found;

    initial begin
        i_rst = 1'b0;
        repeat (3) step();

        chk("rst_a_xx",    32'(vga_a.xx), 32'd14);
        chk("rst_a_yy",    32'(vga_a.yy), 32'd9);
        chk("rst_a_act",   32'(vga_a.aactive), 32'd0);
        chk("rst_a_hs",    32'(vga_a.o_hs), 32'd1);
        chk("rst_a_vs",    32'(vga_a.o_vs), 32'd1);
        chk("rst_a_stb",   32'(vga_a.o_pix_stb), 32'd0);
        chk("rst_a_fs",    32'(vga_a.o_frame_start), 32'd0);
        chk("rst_a_cnt",   32'(vga_a.o_frame_cnt), 32'hFFFF);
        chk("rst_b_hs",    32'(vga_b.o_hs), 32'd0);
        chk("rst_b_vs",    32'(vga_b.o_vs), 32'd0);
        chk("rst_d_xx",    32'(vga_d.xx), 32'd799);
        chk("rst_d_yy",    32'(vga_d.yy), 32'd524);
        chk("rst_d_hsvs",  32'({vga_d.o_hs, vga_d.o_vs}), 32'd3);

        i_rst = 1'b1;
        step();
        chk("b_first_xy",  32'({vga_b.xx, vga_b.yy}), 32'd0);
        chk("b_first_fs",  32'(vga_b.o_frame_start), 32'd1);
        chk("b_first_cnt", 32'(vga_b.o_frame_cnt), 32'd0);
        chk("b_first_stb", 32'(vga_b.o_pix_stb), 32'd1);
        step();
        step();
        chk("a_hold_e3_xx", 32'(vga_a.xx), 32'd14);
        chk("a_stb_e3",     32'(vga_a.o_pix_stb), 32'd1);
        chk("d_hold_e3_xx", 32'(vga_d.xx), 32'd799);
        step();
        chk("a_first_xx",  32'(vga_a.xx), 32'd0);
        chk("a_first_yy",  32'(vga_a.yy), 32'd0);
        chk("a_first_act", 32'(vga_a.aactive), 32'd1);
        chk("a_first_ls",  32'(vga_a.o_line_start), 32'd1);
        chk("a_first_fs",  32'(vga_a.o_frame_start), 32'd1);
        chk("a_first_cnt", 32'(vga_a.o_frame_cnt), 32'd0);
        chk("a_first_stb", 32'(vga_a.o_pix_stb), 32'd0);
        chk("d_first_xy",  32'({vga_d.xx, vga_d.yy}), 32'd0);
        chk("d_first_fs",  32'(vga_d.o_frame_start), 32'd1);
        chk("b_e4_xx",     32'(vga_b.xx), 32'd3);
        chk("b_e4_fs",     32'(vga_b.o_frame_start), 32'd0);

        // Free run from sample k=5 to k=3204 (k counts edges since reset release)
        mdiv = 0; mx = 0; my = 0; mis_a = 0;
        a_stb = 0; a_ls = 0; a_hs_low = 0; a_vs_low = 0; a_act = 0;
        b_stb = 0; b_hs_hi = 0; b_vs_hi = 0;
        d_hs_low = 0; d_act = 0; d_ls = 0; d_max_x = 0;
        for (int k = 5; k <= 3204; k++) begin
            step();
            e_ls = 1'b0;
            if (mdiv == 3) begin
                mx = (mx == 14) ? 0 : mx + 1;
                if (mx == 0) my = (my == 9) ? 0 : my + 1;
                e_ls = (mx == 0);
            end
            mdiv = (mdiv + 1) % 4;
            e_stb = (mdiv == 3);
            e_fs  = e_ls && (my == 0);
            e_hs  = !(mx >= 10 && mx <= 12);
            e_vs  = !(my >= 7 && my <= 8);
            e_act = (mx < 8) && (my < 6);
            if (vga_a.xx !== 10'(mx) || vga_a.yy !== 10'(my) || vga_a.o_pix_stb !== e_stb ||
                vga_a.o_hs !== e_hs || vga_a.o_vs !== e_vs || vga_a.aactive !== e_act ||
                vga_a.o_line_start !== e_ls || vga_a.o_frame_start !== e_fs)
                mis_a++;

            if (k <= 1204) begin
                a_stb    += int'(vga_a.o_pix_stb);
                a_ls     += int'(vga_a.o_line_start);
                a_hs_low += int'(!vga_a.o_hs);
                a_vs_low += int'(!vga_a.o_vs);
                a_act    += int'(vga_a.aactive);
                if (vga_a.o_frame_start) begin
                    a_fs_k.push_back(k);
                    a_fs_cnt.push_back(int'(vga_a.o_frame_cnt));
                end
                b_stb   += int'(vga_b.o_pix_stb);
                b_hs_hi += int'(vga_b.o_hs);
                b_vs_hi += int'(vga_b.o_vs);
                if (vga_b.o_frame_start) b_fs_k.push_back(k);
            end

            d_hs_low += int'(!vga_d.o_hs);
            d_act    += int'(vga_d.aactive);
            d_ls     += int'(vga_d.o_line_start);
            if (int'(vga_d.xx) > d_max_x) d_max_x = int'(vga_d.xx);
        end

        chk("a_model_mismatches", 32'(mis_a), 32'd0);
        chk("a_stb_count",   32'(a_stb), 32'd300);
        chk("a_line_starts", 32'(a_ls), 32'd20);
        chk("a_hs_low",      32'(a_hs_low), 32'd240);
        chk("a_vs_low",      32'(a_vs_low), 32'd240);
        chk("a_active",      32'(a_act), 32'd384);
        chk("a_fs_events",   32'(a_fs_k.size()), 32'd2);
        if (a_fs_k.size() == 2) begin
            chk("a_fs_first_k", 32'(a_fs_k[0]), 32'd604);
            chk("a_fs_spacing", 32'(a_fs_k[1] - a_fs_k[0]), 32'd600);
            chk("a_cnt_frame1", 32'(a_fs_cnt[0]), 32'd1);
            chk("a_cnt_frame2", 32'(a_fs_cnt[1]), 32'd2);
        end
        chk("a_cnt_end",     32'(vga_a.o_frame_cnt), 32'd5);
        chk("b_stb_const",   32'(b_stb), 32'd1200);
        chk("b_hs_high",     32'(b_hs_hi), 32'd240);
        chk("b_vs_high",     32'(b_vs_hi), 32'd240);
        chk("b_fs_events",   32'(b_fs_k.size()), 32'd8);
        if (b_fs_k.size() >= 2)
            chk("b_fs_spacing", 32'(b_fs_k[1] - b_fs_k[0]), 32'd150);
        chk("b_cnt_end",     32'(vga_b.o_frame_cnt), 32'd21);
        chk("d_hs_low",      32'(d_hs_low), 32'd384);
        chk("d_active",      32'(d_act), 32'd2560);
        chk("d_line_starts", 32'(d_ls), 32'd1);
        chk("d_max_xx",      32'(d_max_x), 32'd799);
        chk("d_end_xy",      32'({vga_d.xx, vga_d.yy}), 32'({10'd0, 10'd1}));

        // Assert reset mid-line while a line_start pulse is high
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            step();
            if (vga_a.xx == 10'd0 && vga_a.yy == 10'd3) found = 1'b1;
        end
        chk("wait_a_line3", 32'(found), 32'd1);
        chk("a_ls_before_rst", 32'(vga_a.o_line_start), 32'd1);
        #2 i_rst = 1'b0;
        #1;
        chk("async_a_xx",  32'(vga_a.xx), 32'd14);
        chk("async_a_yy",  32'(vga_a.yy), 32'd9);
        chk("async_a_ls",  32'(vga_a.o_line_start), 32'd0);
        chk("async_a_cnt", 32'(vga_a.o_frame_cnt), 32'hFFFF);
        chk("async_a_act", 32'(vga_a.aactive), 32'd0);
        chk("async_b_stb", 32'(vga_b.o_pix_stb), 32'd0);
        chk("async_b_vs",  32'(vga_b.o_vs), 32'd0);
        chk("async_d_xx",  32'(vga_d.xx), 32'd799);
        repeat (2) step();
        i_rst = 1'b1;
        repeat (3) step();
        chk("re_a_hold_xx", 32'(vga_a.xx), 32'd14);
        step();
        chk("re_a_xy",  32'({vga_a.xx, vga_a.yy}), 32'd0);
        chk("re_a_fs",  32'(vga_a.o_frame_start), 32'd1);
        chk("re_a_cnt", 32'(vga_a.o_frame_cnt), 32'd0);
        chk("re_d_xy",  32'({vga_d.xx, vga_d.yy}), 32'd0);
        step();
        chk("re_a_fs_drop", 32'(vga_a.o_frame_start), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
